rs_issue_scheduler: RTL
=======================

# rs_issue_scheduler

Wakeup/select controller for the 16-entry reservation station. It tracks each entry's lifecycle and source readiness using physical-register wakeup broadcasts. Each cycle it picks, per functional unit, the oldest ready entry (by ROB age) and issues it. One cycle after issue it drives the `clear_rs` indices that free those entries. It sits between Dispatch (allocation) and the three functional units: FU0 = ALU0, FU1 = ALU1, FU2 = LSU.

## Interface
- `RS_DEPTH`, 16: reservation-station entries; index width 4.
- `NUM_FU`, 3: functional units; one select port each.
- `PREG_W`, 6: physical register tag width.
- `AGE_W`, 6: ROB number width; ages compare modulo 2^AGE_W.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alloc_valid`  in  2  per-slot allocation strobe; slot 0 is older than slot 1.
- `alloc_idx[0:1]`  in  4  RS entry written by each slot.
- `alloc_src1_tag[0:1]`, `alloc_src2_tag[0:1]`  in  PREG_W  source physical tags.
- `alloc_src1_rdy[0:1]`, `alloc_src2_rdy[0:1]`  in  1  source already ready at dispatch.
- `alloc_fu[0:1]`  in  2  target FU, 0..2; value 3 is illegal.
- `alloc_age[0:1]`  in  AGE_W  ROB number.
- `rob_head`  in  AGE_W  oldest in-flight ROB number; reference point for age compare.
- `wake_valid`  in  3  per-FU result broadcast.
- `wake_tag[0:2]`  in  PREG_W  destination tag being woken.
- `fu_ready`  in  3  FU can accept an issue this cycle.
- `flush`  in  1  synchronous squash of all entries.
- `issue_valid`  out  3  registered issue strobe per FU.
- `issue_idx[0:2]`  out  4  RS entry issued to each FU.
- `clear_valid`  out  3  registered strobe qualifying `clear_rs`.
- `clear_rs[0:2]`  out  4  RS entry to zero in Dispatch.
- `rs_busy`  out  16  entry is not EMPTY.
- `free_count`  out  5  number of EMPTY entries, 0..16.
- `alloc_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Each entry has a 2-bit state: EMPTY, WAIT, READY, ISSUED. Each entry also stores src tags, src ready bits, fu and age.
- Allocation:
  - A valid slot writes its entry. The entry becomes READY if both sources are ready after bypass, otherwise WAIT.
  - Same-cycle wakeup bypass: a `wake_tag` matching an alloc tag sets that ready bit at the write.
- Illegal allocation: the write is dropped and `alloc_err` is set if any of these hold:
  - the target entry is not EMPTY;
  - `alloc_fu`==3;
  - both slots target the same index (slot 1 is dropped).
- Wakeup: every valid `wake_tag` is compared against all WAIT-entry source tags. Matching ready bits are set. An entry with both bits set moves WAIT→READY at the edge.
- Select, combinational on registered state:
  - For FU f, candidates are READY entries with fu==f.
  - The winner has the smallest (age − `rob_head`) mod 2^AGE_W. Ties go to the lower index.
  - The winner issues only if `fu_ready[f]` is high; it then moves READY→ISSUED.
- Clear: every entry that is ISSUED at an edge moves to EMPTY at that edge. Its index is reported on `clear_rs`/`clear_valid` in the lane of the FU it issued to.
- `flush`:
  - all entries go to EMPTY;
  - `issue_valid` and `clear_valid` are forced to 0 for the next cycle;
  - any allocation in the same cycle is dropped, and `flush` wins.
- `free_count` = popcount of EMPTY entries from registered state. `rs_busy` = ~EMPTY.
- Reset values: all entries EMPTY; `issue_valid`=0, `clear_valid`=0; `issue_idx`=0, `clear_rs`=0; `rs_busy`=0; `free_count`=16; `alloc_err`=0.

## Timing
- Allocation with both sources ready at edge t:
  - entry is READY after t and is selected in cycle t..t+1;
  - `issue_valid` is high after edge t+1;
  - `clear_valid` is high after edge t+2, and the entry is EMPTY after t+2.
- A wakeup presented before edge t makes its consumer READY after t. The consumer can issue no earlier than after t+1.
- When `fu_ready[f]`=0, the entry stays READY and no state changes. Selection re-arbitrates every cycle, so an older arrival can overtake.
- An entry can be both cleared and reallocated at the same edge: it is freed at t and an alloc written at t+1 is legal. An allocation into an ISSUED entry in the same cycle is an error.
- Assertion of `rst_n` low mid-operation clears all outputs immediately, asynchronously. State resumes on the first edge after deassertion.

## Test plan
- Reset then alloc idx 3, fu 0, age 5, both ready, `fu_ready`=111 -> `issue_valid`=001 with `issue_idx[0]`=3 after edge 2; `clear_valid`=001 with `clear_rs[0]`=3 after edge 3; `free_count` 16→15→16.
- Alloc idx 0 (age 9) and idx 1 (age 8), both fu 1 and ready, `rob_head`=8 -> idx 1 issues first, idx 0 issues on the following cycle.
- Age wrap: `rob_head`=62; entries age 63 (idx 4) and age 1 (idx 2), same FU -> idx 4 issues first.
- Alloc idx 5 with src1 tag 17 not ready; `wake_valid[2]` with tag 17 two cycles later -> issue exactly 2 edges after the wakeup. Repeat with the wakeup in the alloc cycle -> issue at the same latency as an all-ready alloc.
- Hold `fu_ready[2]`=0 for 4 cycles with an LSU entry READY -> no issue and entry stays busy; release -> issue on the next edge.
- Alloc into a busy index, and alloc with fu=3 -> write ignored, `alloc_err`=1 until reset. `flush` with 6 busy entries -> `free_count`=16 next cycle and no issue or clear strobes.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Wakeup/select controller for a 16-entry reservation station: tracks each entry
// through EMPTY/WAIT/READY/ISSUED and issues the oldest ready entry to each FU.
module rs_issue_scheduler #(
    parameter int RS_DEPTH = 16,
    parameter int NUM_FU   = 3,
    parameter int PREG_W   = 6,
    parameter int AGE_W    = 6,
    localparam int IDX_W   = $clog2(RS_DEPTH),
    localparam int CNT_W   = $clog2(RS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          alloc_valid,
    input  logic [IDX_W-1:0]    alloc_idx      [0:1],
    input  logic [PREG_W-1:0]   alloc_src1_tag [0:1],
    input  logic [PREG_W-1:0]   alloc_src2_tag [0:1],
    input  logic                alloc_src1_rdy [0:1],
    input  logic                alloc_src2_rdy [0:1],
    input  logic [1:0]          alloc_fu       [0:1],
    input  logic [AGE_W-1:0]    alloc_age      [0:1],
    input  logic [AGE_W-1:0]    rob_head,
    input  logic [NUM_FU-1:0]   wake_valid,
    input  logic [PREG_W-1:0]   wake_tag       [0:NUM_FU-1],
    input  logic [NUM_FU-1:0]   fu_ready,
    input  logic                flush,
    output logic [NUM_FU-1:0]   issue_valid,
    output logic [IDX_W-1:0]    issue_idx      [0:NUM_FU-1],
    output logic [NUM_FU-1:0]   clear_valid,
    output logic [IDX_W-1:0]    clear_rs       [0:NUM_FU-1],
    output logic [RS_DEPTH-1:0] rs_busy,
    output logic [CNT_W-1:0]    free_count,
    output logic                alloc_err
);

    typedef enum logic [1:0] {EMPTY, WAIT, READY, ISSUED} state_e;

    state_e              state     [RS_DEPTH];
    state_e              state_nxt [RS_DEPTH];
    logic [PREG_W-1:0]   src1_tag  [RS_DEPTH];
    logic [PREG_W-1:0]   src2_tag  [RS_DEPTH];
    logic [RS_DEPTH-1:0] src1_rdy, src2_rdy;
    logic [1:0]          ent_fu    [RS_DEPTH];
    logic [AGE_W-1:0]    ent_age   [RS_DEPTH];

    logic [RS_DEPTH-1:0] src1_hit, src2_hit;
    logic [1:0]          alloc_s1_hit, alloc_s2_hit, alloc_legal, alloc_wr;
    logic [AGE_W-1:0]    rel_age   [RS_DEPTH];
    logic [AGE_W-1:0]    best_age  [NUM_FU];
    logic [IDX_W-1:0]    sel_idx   [NUM_FU];
    logic [NUM_FU-1:0]   sel_found, issue_go;

    // Tag match of every broadcast against stored and incoming source tags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        src1_hit     = '0;
        src2_hit     = '0;
        alloc_s1_hit = '0;
        alloc_s2_hit = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (wake_valid[f]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (src1_tag[i] == wake_tag[f]) src1_hit[i] = 1'b1;
                    if (src2_tag[i] == wake_tag[f]) src2_hit[i] = 1'b1;
                end
                for (int s = 0; s < 2; s++) begin
                    if (alloc_src1_tag[s] == wake_tag[f]) alloc_s1_hit[s] = 1'b1;
                    if (alloc_src2_tag[s] == wake_tag[f]) alloc_s2_hit[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++)
            alloc_legal[s] = (state[alloc_idx[s]] == EMPTY) && (alloc_fu[s] != 2'd3);
        if (alloc_valid[0] && alloc_idx[0] == alloc_idx[1]) alloc_legal[1] = 1'b0;
        alloc_wr = alloc_valid & alloc_legal & {2{~flush}};
    end

    // Oldest-first select: age is measured relative to rob_head so wrap is handled.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) rel_age[i] = ent_age[i] - rob_head;
        for (int f = 0; f < NUM_FU; f++) begin
            sel_found[f] = 1'b0;
            sel_idx[f]   = '0;
            best_age[f]  = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (state[i] == READY && ent_fu[i] == 2'(f) &&
                    (!sel_found[f] || rel_age[i] < best_age[f])) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(i);
                    best_age[f]  = rel_age[i];
                end
            end
        end
        issue_go = sel_found & fu_ready;
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                WAIT:
                    if ((src1_rdy[i] || src1_hit[i]) && (src2_rdy[i] || src2_hit[i]))
                        state_nxt[i] = READY;
                READY:
                    for (int f = 0; f < NUM_FU; f++)
                        if (issue_go[f] && sel_idx[f] == IDX_W'(i)) state_nxt[i] = ISSUED;
                ISSUED:  state_nxt[i] = EMPTY;
                default: ;
            endcase
        end
        for (int s = 0; s < 2; s++) begin
            if (alloc_wr[s])
                state_nxt[alloc_idx[s]] =
                    ((alloc_src1_rdy[s] || alloc_s1_hit[s]) && (alloc_src2_rdy[s] || alloc_s2_hit[s]))
                    ? READY : WAIT;
        end
        if (flush)
            for (int i = 0; i < RS_DEPTH; i++) state_nxt[i] = EMPTY;
    end

    // NOTE: payload is not reset; it is meaningless while EMPTY and fully rewritten on allocation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (state[i] == WAIT) begin
                if (src1_hit[i]) src1_rdy[i] <= 1'b1;
                if (src2_hit[i]) src2_rdy[i] <= 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (alloc_wr[s]) begin
                src1_tag[alloc_idx[s]] <= alloc_src1_tag[s];
                src2_tag[alloc_idx[s]] <= alloc_src2_tag[s];
                src1_rdy[alloc_idx[s]] <= alloc_src1_rdy[s] | alloc_s1_hit[s];
                src2_rdy[alloc_idx[s]] <= alloc_src2_rdy[s] | alloc_s2_hit[s];
                ent_fu[alloc_idx[s]]   <= alloc_fu[s];
                ent_age[alloc_idx[s]]  <= alloc_age[s];
            end
        end
    end

    // An entry is ISSUED for exactly one cycle, so the clear lane is the issue lane delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) state[i] <= EMPTY;
            issue_valid <= '0;
            clear_valid <= '0;
            alloc_err   <= 1'b0;
            for (int f = 0; f < NUM_FU; f++) begin
                issue_idx[f] <= '0;
                clear_rs[f]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < RS_DEPTH; i++) state[i] <= state_nxt[i];
            issue_valid <= flush ? '0 : issue_go;
            clear_valid <= flush ? '0 : issue_valid;
            for (int f = 0; f < NUM_FU; f++) begin
                if (issue_go[f])    issue_idx[f] <= sel_idx[f];
                if (issue_valid[f]) clear_rs[f]  <= issue_idx[f];
            end
            if (|(alloc_valid & ~alloc_legal)) alloc_err <= 1'b1;
        end
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rs_busy[i] = (state[i] != EMPTY);
            free_count = free_count + CNT_W'(state[i] == EMPTY);
        end
    end

endmodule
